// File: rtl/reg_bus_bridge_if.sv
// AXI4-Lite register-access channels between a host and reg_bus_bridge.
// Full-word writes only, so the bundle carries no write strobes.
interface reg_bus_bridge_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH+1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH+1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/reg_bus_bridge.sv
// AXI4-Lite slave driving the internal CPU register bus with fixed-length
// read/write strobes; one transaction at a time, round-robin between reads and writes.
module reg_bus_bridge #(
  parameter int ADDR_WIDTH = 16,
  parameter int RD_CYC     = 4,
  parameter int WR_CYC     = 2
) (
  input  logic                  clks,
  input  logic                  reset,
  reg_bus_bridge_if.slave       s,
  output logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  cpu_rd,
  output logic                  cpu_rd_dly1,
  output logic                  cpu_wr,
  output logic [31:0]           cpu_data_in,
  input  logic [31:0]           cpu_data_out
);

  localparam int MAX_CYC = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYC - 1);

  typedef enum logic [2:0] {IDLE, RD, WR, RRSP, WRSP} state_t;

  state_t                state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  prio_wr_reg;
  logic [ADDR_WIDTH-1:0] cpu_addr_reg;
  logic [31:0]           cpu_data_in_reg;
  logic                  cpu_rd_reg;
  logic                  cpu_rd_dly1_reg;
  logic                  cpu_wr_reg;
  logic [31:0]           rdata_reg;
  logic                  rvalid_reg;
  logic                  bvalid_reg;

  logic rd_pend;
  logic wr_pend;
  logic take_rd;
  logic take_wr;

  // Ready must coincide with valid in the same cycle, so the accept decision
  // is combinational; reset gates it so nothing is accepted while held.
  always_comb begin
    rd_pend = s.arvalid;
    wr_pend = s.awvalid & s.wvalid;
    take_rd = 1'b0;
    take_wr = 1'b0;
    if (reset && state_reg == IDLE) begin
      if (rd_pend && (!wr_pend || !prio_wr_reg)) begin
        take_rd = 1'b1;
      end else if (wr_pend) begin
        take_wr = 1'b1;
      end
    end
  end

  always_ff @(posedge clks) begin
    if (!reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      prio_wr_reg     <= 1'b0;
      cpu_addr_reg    <= '0;
      cpu_data_in_reg <= '0;
      cpu_rd_reg      <= 1'b0;
      cpu_rd_dly1_reg <= 1'b0;
      cpu_wr_reg      <= 1'b0;
      rdata_reg       <= '0;
      rvalid_reg      <= 1'b0;
      bvalid_reg      <= 1'b0;
    end else begin
      cpu_rd_dly1_reg <= cpu_rd_reg;
      case (state_reg)
        IDLE: begin
          if (take_rd) begin
            cpu_addr_reg <= s.araddr[ADDR_WIDTH+1:2];
            cpu_rd_reg   <= 1'b1;
            cnt_reg      <= '0;
            prio_wr_reg  <= 1'b1;
            state_reg    <= RD;
          end else if (take_wr) begin
            cpu_addr_reg    <= s.awaddr[ADDR_WIDTH+1:2];
            cpu_data_in_reg <= s.wdata;
            cpu_wr_reg      <= 1'b1;
            cnt_reg         <= '0;
            prio_wr_reg     <= 1'b0;
            state_reg       <= WR;
          end
        end
        RD: begin
          // Read-back bus is sampled on the final strobe cycle, after the slice has settled.
          if (cnt_reg == RD_LAST) begin
            cpu_rd_reg <= 1'b0;
            rdata_reg  <= cpu_data_out;
            rvalid_reg <= 1'b1;
            state_reg  <= RRSP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RRSP: begin
          if (s.rready) begin
            rvalid_reg <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        WR: begin
          if (cnt_reg == WR_LAST) begin
            cpu_wr_reg <= 1'b0;
            bvalid_reg <= 1'b1;
            state_reg  <= WRSP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WRSP: begin
          if (s.bready) begin
            bvalid_reg <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign s.arready   = take_rd;
  assign s.awready   = take_wr;
  assign s.wready    = take_wr;
  assign s.rdata     = rdata_reg;
  assign s.rresp     = 2'b00;
  assign s.rvalid    = rvalid_reg;
  assign s.bresp     = 2'b00;
  assign s.bvalid    = bvalid_reg;
  assign cpu_addr    = cpu_addr_reg;
  assign cpu_rd      = cpu_rd_reg;
  assign cpu_rd_dly1 = cpu_rd_dly1_reg;
  assign cpu_wr      = cpu_wr_reg;
  assign cpu_data_in = cpu_data_in_reg;

endmodule

// File: tb/tb_reg_bus_bridge.sv
// Directed bench for reg_bus_bridge: reset, single read/write timing,
// read/write arbitration, response back-pressure and reset mid-read.
module tb_reg_bus_bridge;
  localparam int AW = 16;

  logic          clks = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_addr;
  logic          cpu_rd;
  logic          cpu_rd_dly1;
  logic          cpu_wr;
  logic [31:0]   cpu_data_in;
  logic [31:0]   cpu_data_out;

  int checks   = 0;
  int failures = 0;

  reg_bus_bridge_if #(.ADDR_WIDTH(AW)) bus_if ();

  reg_bus_bridge #(.ADDR_WIDTH(AW), .RD_CYC(4), .WR_CYC(2)) dut (
    .clks         (clks),
    .reset        (reset),
    .s            (bus_if),
    .cpu_addr     (cpu_addr),
    .cpu_rd       (cpu_rd),
    .cpu_rd_dly1  (cpu_rd_dly1),
    .cpu_wr       (cpu_wr),
    .cpu_data_in  (cpu_data_in),
    .cpu_data_out (cpu_data_out)
  );

  always #5 clks = ~clks;

  task automatic tick();
    @(posedge clks);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for rvalid, checks the response, then completes the handshake.
  task automatic finish_read(input string tag, input logic [31:0] exp_data);
    int n = 0;
    while (bus_if.rvalid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_rvalid"}, {31'd0, bus_if.rvalid}, 32'd1);
    chk({tag, "_rdata"}, bus_if.rdata, exp_data);
    chk({tag, "_rresp"}, {30'd0, bus_if.rresp}, 32'd0);
    $display("txn %s read addr=%h data=%h", tag, cpu_addr, bus_if.rdata);
    bus_if.rready = 1'b1;
    tick();
    bus_if.rready = 1'b0;
    #1;
    chk({tag, "_rvalid_clr"}, {31'd0, bus_if.rvalid}, 32'd0);
  endtask

  logic order_q [4];
  int   n_acc;
  int   cyc;

  initial begin
    reset          = 1'b0;
    bus_if.awaddr  = '0;
    bus_if.awvalid = 1'b0;
    bus_if.wdata   = '0;
    bus_if.wvalid  = 1'b0;
    bus_if.bready  = 1'b0;
    bus_if.araddr  = 18'h00004;
    bus_if.arvalid = 1'b1;
    bus_if.rready  = 1'b0;
    cpu_data_out   = 32'h1111_1111;

    // Reset held with a pending read: nothing may be accepted
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_arready", {31'd0, bus_if.arready}, 32'd0);
    end
    chk("rst_cpu_rd", {31'd0, cpu_rd}, 32'd0);
    chk("rst_cpu_rd_dly1", {31'd0, cpu_rd_dly1}, 32'd0);
    chk("rst_cpu_wr", {31'd0, cpu_wr}, 32'd0);
    chk("rst_cpu_addr", {16'd0, cpu_addr}, 32'd0);
    chk("rst_cpu_data_in", cpu_data_in, 32'd0);
    chk("rst_rdata", bus_if.rdata, 32'd0);
    chk("rst_valids", {30'd0, bus_if.rvalid, bus_if.bvalid}, 32'd0);
    chk("rst_wready", {30'd0, bus_if.awready, bus_if.wready}, 32'd0);
    chk("rst_resp", {28'd0, bus_if.rresp, bus_if.bresp}, 32'd0);

    reset = 1'b1;
    #1;
    chk("rel_arready", {31'd0, bus_if.arready}, 32'd1);
    tick();
    bus_if.arvalid = 1'b0;
    #1;
    chk("rel_cpu_rd", {31'd0, cpu_rd}, 32'd1);
    chk("rel_cpu_addr", {16'd0, cpu_addr}, 32'h0001);
    finish_read("rel", 32'h1111_1111);

    // Single read with cycle-exact strobe timing
    cpu_data_out   = 32'hA5A5_5A5A;
    bus_if.araddr  = 18'h00008;
    bus_if.arvalid = 1'b1;
    #1;
    chk("rd_arready", {31'd0, bus_if.arready}, 32'd1);
    tick();
    bus_if.arvalid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("rd_cpu_rd_c%0d", i), {31'd0, cpu_rd}, {31'd0, (i <= 4)});
      chk($sformatf("rd_dly1_c%0d", i), {31'd0, cpu_rd_dly1}, {31'd0, (i >= 2)});
      chk($sformatf("rd_rvalid_c%0d", i), {31'd0, bus_if.rvalid}, {31'd0, (i == 5)});
      if (i < 5) tick();
    end
    chk("rd_cpu_addr", {16'd0, cpu_addr}, 32'h0002);
    finish_read("rd", 32'hA5A5_5A5A);

    // Single write
    bus_if.awaddr  = 18'h00010;
    bus_if.wdata   = 32'h1234_5678;
    bus_if.awvalid = 1'b1;
    bus_if.wvalid  = 1'b1;
    #1;
    chk("wr_ready", {30'd0, bus_if.awready, bus_if.wready}, 32'd3);
    tick();
    bus_if.awvalid = 1'b0;
    bus_if.wvalid  = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("wr_cpu_wr_c%0d", i), {31'd0, cpu_wr}, {31'd0, (i <= 2)});
      chk($sformatf("wr_bvalid_c%0d", i), {31'd0, bus_if.bvalid}, {31'd0, (i == 3)});
      if (i < 3) tick();
    end
    chk("wr_cpu_addr", {16'd0, cpu_addr}, 32'h0004);
    chk("wr_cpu_data_in", cpu_data_in, 32'h1234_5678);
    chk("wr_bresp", {30'd0, bus_if.bresp}, 32'd0);
    $display("txn wr write addr=%h data=%h", cpu_addr, cpu_data_in);
    bus_if.bready = 1'b1;
    tick();
    bus_if.bready = 1'b0;
    chk("wr_bvalid_clr", {31'd0, bus_if.bvalid}, 32'd0);
    chk("wr_addr_hold", {16'd0, cpu_addr}, 32'h0004);

    // Reads and writes all pending: last served was a write, so read goes first
    cpu_data_out   = 32'hCAFE_0001;
    bus_if.araddr  = 18'h00040;
    bus_if.awaddr  = 18'h00044;
    bus_if.wdata   = 32'h0000_0055;
    bus_if.arvalid = 1'b1;
    bus_if.awvalid = 1'b1;
    bus_if.wvalid  = 1'b1;
    bus_if.rready  = 1'b1;
    bus_if.bready  = 1'b1;
    #1;
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 4 && cyc < 200) begin
      chk("arb_strobe_excl", {31'd0, cpu_rd & cpu_wr}, 32'd0);
      chk("arb_accept_excl", {31'd0, bus_if.arready & bus_if.awready}, 32'd0);
      if (bus_if.arready) begin
        order_q[n_acc] = 1'b0;
        n_acc++;
        $display("txn arb read accepted");
      end else if (bus_if.awready) begin
        order_q[n_acc] = 1'b1;
        n_acc++;
        $display("txn arb write accepted");
      end
      tick();
      cyc++;
    end
    bus_if.arvalid = 1'b0;
    bus_if.awvalid = 1'b0;
    bus_if.wvalid  = 1'b0;
    chk("arb_count", n_acc, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("arb_order_%0d", i), {31'd0, order_q[i]}, {31'd0, (i % 2 == 1)});
    end
    for (int i = 0; i < 10; i++) begin
      chk("arb_drain_excl", {31'd0, cpu_rd & cpu_wr}, 32'd0);
      tick();
    end
    bus_if.rready = 1'b0;
    bus_if.bready = 1'b0;
    chk("arb_idle", {30'd0, bus_if.rvalid, bus_if.bvalid}, 32'd0);

    // rready held low: response must stay frozen and no new read accepted
    cpu_data_out   = 32'hDEAD_BEEF;
    bus_if.araddr  = 18'h00020;
    bus_if.arvalid = 1'b1;
    #1;
    tick();
    cyc = 0;
    while (bus_if.rvalid !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
    for (int i = 0; i < 10; i++) begin
      cpu_data_out = $urandom;
      #1;
      chk("stall_rvalid", {31'd0, bus_if.rvalid}, 32'd1);
      chk("stall_rdata", bus_if.rdata, 32'hDEAD_BEEF);
      chk("stall_arready", {31'd0, bus_if.arready}, 32'd0);
      chk("stall_cpu_rd", {31'd0, cpu_rd}, 32'd0);
      tick();
    end
    $display("txn stall read addr=%h data=%h", cpu_addr, bus_if.rdata);
    cpu_data_out  = 32'h0000_0077;
    bus_if.rready = 1'b1;
    #1;
    chk("b2b_arready_hs", {31'd0, bus_if.arready}, 32'd0);
    tick();
    bus_if.rready = 1'b0;
    #1;
    chk("b2b_rvalid_clr", {31'd0, bus_if.rvalid}, 32'd0);
    chk("b2b_arready_next", {31'd0, bus_if.arready}, 32'd1);
    tick();
    bus_if.arvalid = 1'b0;
    finish_read("b2b", 32'h0000_0077);

    // Reset in the second RD cycle
    bus_if.araddr  = 18'h00030;
    bus_if.arvalid = 1'b1;
    #1;
    chk("rstmid_arready", {31'd0, bus_if.arready}, 32'd1);
    tick();
    bus_if.arvalid = 1'b0;
    tick();
    chk("rstmid_cpu_rd_c2", {31'd0, cpu_rd}, 32'd1);
    reset = 1'b0;
    tick();
    chk("rstmid_cpu_rd_drop", {31'd0, cpu_rd}, 32'd0);
    chk("rstmid_rvalid", {31'd0, bus_if.rvalid}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rstmid_no_rsp", {30'd0, bus_if.rvalid, cpu_rd}, 32'd0);
    end
    $display("txn rstmid read aborted by reset");

    // Normal read afterwards
    cpu_data_out   = 32'h0BAD_F00D;
    bus_if.araddr  = 18'h0003C;
    bus_if.arvalid = 1'b1;
    #1;
    chk("post_arready", {31'd0, bus_if.arready}, 32'd1);
    tick();
    bus_if.arvalid = 1'b0;
    chk("post_cpu_addr", {16'd0, cpu_addr}, 32'h000F);
    finish_read("post", 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
